// File: rtl/calc_pkg.sv
// ----------------------------------------------------------------------------
// calc_pkg
//   Definitions shared by the calculator datapath blocks (multiply, divide,
//   ALU operation selector): default operand width and the common
//   IDLE/BUSY/DONE state encoding used by the sequential units.
// ----------------------------------------------------------------------------
package calc_pkg;

  // Default operand/result width of the calculator datapath.
  localparam int CALC_WIDTH = 8;

  // Raw state codes, kept as plain constants so units that do not use the
  // enum (e.g. the ALU selector decoding status) agree on the encoding.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_BUSY = ST_BUSY,
    S_DONE = ST_DONE
  } calc_state_e;

endpackage

// File: rtl/divide_seq_if.sv
// ----------------------------------------------------------------------------
// divide_seq_if
//   Request/result bundle of the sequential divider.
//   master (requester, e.g. ALU selector): drives start, a, b;
//                                          observes out, rem, div_zero,
//                                          busy, done.
//   slave  (divider):                      the mirror image.
//   Signals:
//     start    request pulse, sampled only while the divider is not busy
//     a, b     dividend / divisor, unsigned, WIDTH bits
//     out      quotient, valid from done until the next accepted start
//     rem      remainder, same validity as out
//     div_zero divisor was zero, same validity as out
//     busy     division in progress
//     done     one-cycle pulse, results valid this cycle
// ----------------------------------------------------------------------------
interface divide_seq_if
  import calc_pkg::*;
#(
  parameter int WIDTH = CALC_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] rem;
  logic             div_zero;
  logic             busy;
  logic             done;

  modport master (
    output start, a, b,
    input  out, rem, div_zero, busy, done
  );

  modport slave (
    input  start, a, b,
    output out, rem, div_zero, busy, done
  );

endinterface

// File: rtl/div_step.sv
// ----------------------------------------------------------------------------
// div_step
//   One restoring-division step (combinational).
//   Ports:
//     rem_i    partial remainder before the step (always < divisor)
//     q_msb_i  next dividend bit, taken from the quotient shift register MSB
//     div_i    divisor
//     rem_o    partial remainder after the step
//     q_bit_o  quotient bit produced by this step
// ----------------------------------------------------------------------------
module div_step
  import calc_pkg::*;
#(
  parameter int WIDTH = CALC_WIDTH
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             q_msb_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_bit_o
);

  // The shifted remainder needs WIDTH+1 bits; after a successful subtract it
  // is below the divisor again, so the result always fits back in WIDTH bits.
  logic [WIDTH:0] trial_s;
  logic           ge_s;

  // Shift in the next dividend bit, compare against the divisor and restore.
  always_comb begin
    trial_s = {rem_i, q_msb_i};
    ge_s    = (trial_s >= {1'b0, div_i});
    q_bit_o = ge_s;
    rem_o   = trial_s[WIDTH-1:0];
    if (ge_s) begin
      rem_o = trial_s[WIDTH-1:0] - div_i;
    end else begin
      rem_o = trial_s[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/divide_seq.sv
// ----------------------------------------------------------------------------
// divide_seq
//   Iterative unsigned divider for the calculator datapath, one quotient bit
//   per clock using the restoring algorithm.
//   Ports:
//     clk    single clock, rising edge
//     rst_n  synchronous active-low reset
//     dbus   divide_seq_if.slave: start/a/b in; out/rem/div_zero/busy/done out
//   Timing (accepting edge = edge 0):
//     b != 0 : busy high for WIDTH cycles, done pulses after edge WIDTH+1
//     b == 0 : busy stays low, done pulses after edge 1;
//              out = all ones, rem = a, div_zero = 1
// ----------------------------------------------------------------------------
module divide_seq
  import calc_pkg::*;
#(
  parameter int WIDTH = CALC_WIDTH
) (
  input  logic        clk,
  input  logic        rst_n,
  divide_seq_if.slave dbus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  calc_state_e      state_q;
  logic [CNT_W-1:0] cnt_q;      // quotient bits still to produce
  logic [WIDTH-1:0] rem_q;      // partial remainder
  logic [WIDTH-1:0] quo_q;      // dividend bits shift out, quotient bits in
  logic [WIDTH-1:0] div_q;      // captured divisor
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] rem_out_q;
  logic             dz_q;
  logic             busy_q;
  logic             done_q;

  logic [WIDTH-1:0] rem_d;
  logic             q_bit_d;

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_i   (rem_q),
    .q_msb_i (quo_q[WIDTH-1]),
    .div_i   (div_q),
    .rem_o   (rem_d),
    .q_bit_o (q_bit_d)
  );

  // Control FSM, datapath registers and registered result/status outputs.
  // BUSY with cnt_q == 0 is a wrap-up cycle: the last quotient bit is already
  // in, busy has dropped, and the results are published with the done pulse
  // on the following edge. A zero divisor takes only this wrap-up cycle,
  // which gives it the one-edge latency without ever raising busy. Requests
  // are accepted only from IDLE or DONE, so start during wrap-up is ignored.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= {CNT_W{1'b0}};
      rem_q     <= {WIDTH{1'b0}};
      quo_q     <= {WIDTH{1'b0}};
      div_q     <= {WIDTH{1'b0}};
      out_q     <= {WIDTH{1'b0}};
      rem_out_q <= {WIDTH{1'b0}};
      dz_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (dbus.start) begin
            state_q   <= S_BUSY;
            div_q     <= dbus.b;
            quo_q     <= dbus.a;
            rem_q     <= {WIDTH{1'b0}};
            out_q     <= {WIDTH{1'b0}};
            rem_out_q <= {WIDTH{1'b0}};
            dz_q      <= 1'b0;
            if (dbus.b == {WIDTH{1'b0}}) begin
              cnt_q  <= {CNT_W{1'b0}};
              busy_q <= 1'b0;
            end else begin
              cnt_q  <= CNT_W'(WIDTH);
              busy_q <= 1'b1;
            end
          end else begin
            state_q <= S_IDLE;
          end
        end

        S_BUSY: begin
          if (cnt_q != {CNT_W{1'b0}}) begin
            rem_q  <= rem_d;
            quo_q  <= {quo_q[WIDTH-2:0], q_bit_d};
            cnt_q  <= cnt_q - CNT_W'(1);
            busy_q <= (cnt_q != CNT_W'(1));
          end else begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            if (div_q == {WIDTH{1'b0}}) begin
              // Untouched shift register still holds the dividend.
              out_q     <= {WIDTH{1'b1}};
              rem_out_q <= quo_q;
              dz_q      <= 1'b1;
            end else begin
              out_q     <= quo_q;
              rem_out_q <= rem_q;
              dz_q      <= 1'b0;
            end
          end
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign dbus.out      = out_q;
  assign dbus.rem      = rem_out_q;
  assign dbus.div_zero = dz_q;
  assign dbus.busy     = busy_q;
  assign dbus.done     = done_q;

endmodule
